// File: rtl/bsg_gateway_clk_seq.sv
// Power-up / recovery sequencer for the gateway PLL: pulses the PLL reset,
// filters lock, then releases io, core and microblaze resets in order.
//
// Ports:
//   clk_i          free-running 150 MHz reference (never a PLL output)
//   reset_n_i      asynchronous active-low reset
//   pll_locked_i   raw PLL LOCKED, synchronized internally
//   restart_i      single-cycle synchronous restart request
//   pll_rst_o      PLL reset, active high
//   io_reset_o     io master domain reset, active high
//   core_reset_o   core domain reset, active high
//   mb_reset_o     microblaze domain reset, active high
//   ready_o        all domain resets released
//   error_o        lock retries exhausted
//   lock_lost_o    sticky: lock dropped after release began
//   retry_count_o  timeouts seen in the current sequence
//   state_o        current state encoding
module bsg_gateway_clk_seq #(
    parameter int pll_rst_cycles_p   = 8,
    parameter int lock_filter_p      = 64,
    parameter int lock_timeout_p     = 4096,
    parameter int io_to_core_delay_p = 32,
    parameter int core_to_mb_delay_p = 32,
    parameter int max_retries_p      = 4,
    parameter int retry_width_p      = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     pll_locked_i,
    input  logic                     restart_i,
    output logic                     pll_rst_o,
    output logic                     io_reset_o,
    output logic                     core_reset_o,
    output logic                     mb_reset_o,
    output logic                     ready_o,
    output logic                     error_o,
    output logic                     lock_lost_o,
    output logic [retry_width_p-1:0] retry_count_o,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_REL_IO    = 3'd2,
        S_REL_CORE  = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_e;

    // One timer is shared by every timed state, so size it for the longest.
    localparam int TMAX_A = (pll_rst_cycles_p > lock_timeout_p)
                          ? pll_rst_cycles_p : lock_timeout_p;
    localparam int TMAX_B = (io_to_core_delay_p > core_to_mb_delay_p)
                          ? io_to_core_delay_p : core_to_mb_delay_p;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int FW     = $clog2(lock_filter_p + 1);
    localparam int RW     = retry_width_p;

    localparam logic [TW-1:0] PR_LAST = TW'(pll_rst_cycles_p - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(lock_timeout_p - 1);
    localparam logic [TW-1:0] IC_LAST = TW'(io_to_core_delay_p - 1);
    localparam logic [TW-1:0] CM_LAST = TW'(core_to_mb_delay_p - 1);
    localparam logic [FW-1:0] FILT    = FW'(lock_filter_p);
    localparam logic [RW-1:0] MAXR    = RW'(max_retries_p);

    logic          sync1_q;
    logic          lock_s_q;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] filter_q, filter_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [RW-1:0] retry_inc;
    logic          lost_q, lost_d;
    logic          pll_rst_q, io_q, core_q, mb_q, ready_q, error_q;
    logic          released;

    assign retry_inc = (retry_q == {RW{1'b1}}) ? retry_q : retry_q + RW'(1);
    assign released  = (state_q == S_REL_IO) || (state_q == S_REL_CORE) ||
                       (state_q == S_RUN);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        filter_d = '0;
        retry_d  = retry_q;
        lost_d   = lost_q;
        case (state_q)
            S_PLL_RST: begin
                if (timer_q == PR_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                filter_d = lock_s_q ? filter_q + FW'(1) : '0;
                if (filter_q == FILT) begin
                    state_d = S_REL_IO;
                end else if (timer_q == TO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MAXR) ? S_FAIL : S_PLL_RST;
                end
            end
            S_REL_IO: begin
                if (timer_q == IC_LAST) state_d = S_REL_CORE;
            end
            S_REL_CORE: begin
                if (timer_q == CM_LAST) state_d = S_RUN;
            end
            S_RUN:   timer_d = '0;
            S_FAIL:  timer_d = '0;
            default: state_d = S_PLL_RST;
        endcase
        // Lock loss after release overrides normal progress.
        if (released && !lock_s_q) begin
            state_d = S_PLL_RST;
            lost_d  = 1'b1;
        end
        if (restart_i) begin
            state_d = S_PLL_RST;
            retry_d = '0;
            lost_d  = 1'b0;
        end
        if (restart_i || (state_d != state_q)) begin
            timer_d  = '0;
            filter_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            state_q   <= S_PLL_RST;
            timer_q   <= '0;
            filter_q  <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            io_q      <= 1'b1;
            core_q    <= 1'b1;
            mb_q      <= 1'b1;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            sync1_q   <= pll_locked_i;
            lock_s_q  <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            filter_q  <= filter_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            // Outputs decode the next state so they line up with state_o.
            pll_rst_q <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
            io_q      <= !((state_d == S_REL_IO) || (state_d == S_REL_CORE) ||
                           (state_d == S_RUN));
            core_q    <= !((state_d == S_REL_CORE) || (state_d == S_RUN));
            mb_q      <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
            error_q   <= (state_d == S_FAIL);
        end
    end

    assign pll_rst_o     = pll_rst_q;
    assign io_reset_o    = io_q;
    assign core_reset_o  = core_q;
    assign mb_reset_o    = mb_q;
    assign ready_o       = ready_q;
    assign error_o       = error_q;
    assign lock_lost_o   = lost_q;
    assign retry_count_o = retry_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_bsg_gateway_clk_seq.sv
// Directed bench for bsg_gateway_clk_seq: bring-up timing, lock glitch,
// timeouts to FAIL, lock loss, restart and asynchronous reset.
module tb_bsg_gateway_clk_seq;

    logic       clk;
    logic       reset_n;
    logic       locked;
    logic       restart;
    logic       pll_rst, io_rst, core_rst, mb_rst, ready, error, lost;
    logic [2:0] retry;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string tag;
        int    sel;
        int    val;
        int    cyc;
    } exp_t;
    exp_t sbq[$];

    localparam int S_PLL = 0, S_IO = 1, S_CORE = 2, S_MB = 3, S_RDY = 4;
    localparam int S_ERR = 5, S_LOST = 6, S_RETRY = 7, S_STATE = 8;

    bsg_gateway_clk_seq dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .pll_locked_i (locked),
        .restart_i    (restart),
        .pll_rst_o    (pll_rst),
        .io_reset_o   (io_rst),
        .core_reset_o (core_rst),
        .mb_reset_o   (mb_rst),
        .ready_o      (ready),
        .error_o      (error),
        .lock_lost_o  (lost),
        .retry_count_o(retry),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int get_sig(input int sel);
        case (sel)
            S_PLL:   return {31'd0, pll_rst};
            S_IO:    return {31'd0, io_rst};
            S_CORE:  return {31'd0, core_rst};
            S_MB:    return {31'd0, mb_rst};
            S_RDY:   return {31'd0, ready};
            S_ERR:   return {31'd0, error};
            S_LOST:  return {31'd0, lost};
            S_RETRY: return {29'd0, retry};
            default: return {29'd0, state};
        endcase
    endfunction

    // {pll, io, core, mb, ready, error, lost}
    function automatic int outs();
        return {25'd0, pll_rst, io_rst, core_rst, mb_rst, ready, error, lost};
    endfunction

    task automatic tick();
        logic ok;
        @(posedge clk);
        #1;
        cyc++;
        ok = !((!io_rst || !core_rst || !mb_rst) && pll_rst) &&
             !(!core_rst && io_rst) && !(!mb_rst && core_rst);
        chk("order", {31'd0, ok}, 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_sig(input int sel, input int val, input int budget,
                            output int at);
        int n;
        n = 0;
        while (get_sig(sel) != val && n < budget) begin
            tick();
            n++;
        end
        at = (get_sig(sel) == val) ? cyc : -1;
    endtask

    task automatic push(input string tag, input int sel, input int val,
                        input int c);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        int   at;
        int   budget;
        e = sbq.pop_front();
        budget = (e.cyc > cyc) ? e.cyc - cyc + 10 : 10;
        wait_sig(e.sel, e.val, budget, at);
        chk(e.tag, at, e.cyc);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int at;
        int r;
        int x;
        reset_n = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;

        // Reset state
        chk("rst_outs", outs(), 7'b1111000);
        chk("rst_retry", get_sig(S_RETRY), 0);
        chk("rst_state", get_sig(S_STATE), 0);

        // Nominal bring-up
        until_cyc(7);
        chk("pll_rst_c7", get_sig(S_PLL), 1);
        tick();
        chk("pll_rst_c8", get_sig(S_PLL), 0);
        chk("wait_state", get_sig(S_STATE), 1);
        until_cyc(100);
        locked = 1'b1;
        push("io_fall", S_IO, 0, 167);
        push("core_fall", S_CORE, 0, 199);
        push("mb_fall", S_MB, 0, 231);
        push("ready_rise", S_RDY, 1, 231);
        while (sbq.size() > 0) pop_check();
        chk("run_state", get_sig(S_STATE), 4);
        chk("run_retry", get_sig(S_RETRY), 0);

        // Lock loss in RUN
        ticks(5);
        x = cyc;
        locked = 1'b0;
        tick();
        locked = 1'b1;
        push("loss_state", S_STATE, 0, x + 3);
        pop_check();
        chk("loss_outs", outs(), 7'b1111001);
        r = cyc;
        push("reseq_io", S_IO, 0, r + 73);
        push("reseq_core", S_CORE, 0, r + 105);
        while (sbq.size() > 0) pop_check();

        // Restart in REL_CORE
        ticks(3);
        chk("relcore_state", get_sig(S_STATE), 3);
        pulse_restart();
        chk("rs_core_state", get_sig(S_STATE), 0);
        chk("rs_core_outs", outs(), 7'b1111000);
        chk("rs_core_retry", get_sig(S_RETRY), 0);

        // Lock glitch during filtering
        locked = 1'b0;
        pulse_restart();
        r = cyc;
        until_cyc(r + 20);
        locked = 1'b1;
        until_cyc(r + 61);
        x = cyc;
        locked = 1'b0;
        tick();
        locked = 1'b1;
        push("glitch_io", S_IO, 0, x + 68);
        pop_check();
        chk("glitch_retry", get_sig(S_RETRY), 0);

        // Timeouts to FAIL
        locked = 1'b0;
        pulse_restart();
        for (int k = 1; k <= 4; k++) begin
            wait_sig(S_RETRY, k, 4200, at);
            chk("retry_step", get_sig(S_RETRY), k);
            chk("retry_state", get_sig(S_STATE), (k == 4) ? 5 : 0);
        end
        chk("fail_outs", outs(), 7'b1111010);
        ticks(20);
        chk("fail_hold", get_sig(S_STATE), 5);

        // Restart in FAIL
        pulse_restart();
        chk("rs_fail_state", get_sig(S_STATE), 0);
        chk("rs_fail_outs", outs(), 7'b1111000);
        chk("rs_fail_retry", get_sig(S_RETRY), 0);

        // Async reset mid-REL_IO
        r = cyc;
        locked = 1'b1;
        push("io_after_fail", S_IO, 0, r + 73);
        pop_check();
        ticks(5);
        chk("relio_state", get_sig(S_STATE), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_outs", outs(), 7'b1111000);
        chk("async_state", get_sig(S_STATE), 0);
        chk("async_retry", get_sig(S_RETRY), 0);
        #4;
        reset_n = 1'b1;
        tick();
        chk("post_rst_state", get_sig(S_STATE), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_gateway_clk_seq.md
Name: bsg_gateway_clk_seq

Overview:
- Power-up and recovery sequencer for the gateway clock generator's PLL.
- Pulses the PLL reset, waits for a filtered lock, then releases downstream resets in a fixed order: io master domain, then core domain, then microblaze domain.
- Watches for lock loss and retries on lock timeout.
- Runs on the free-running differential-buffered 150 MHz reference, never on a PLL output.

Parameters:
- pll_rst_cycles_p, 8: cycles pll_rst_o is held high per attempt (min 1).
- lock_filter_p, 64: consecutive synced-lock cycles required before release (min 1).
- lock_timeout_p, 4096: cycles allowed in WAIT_LOCK before a retry; must exceed lock_filter_p.
- io_to_core_delay_p, 32: cycles between io reset release and core reset release (min 1).
- core_to_mb_delay_p, 32: cycles between core reset release and mb reset release (min 1).
- max_retries_p, 4: timeouts tolerated before FAIL (min 1).
- retry_width_p, 3: width of retry_count_o; must hold max_retries_p.

Ports:
- clk_i  in  1  free-running reference clock
- reset_n_i  in  1  asynchronous active-low reset
- pll_locked_i  in  1  PLL LOCKED; asynchronous, synchronized internally through 2 flops (lock_s)
- restart_i  in  1  synchronous single-cycle restart request
- pll_rst_o  out  1  PLL RST, active high
- io_reset_o  out  1  io master domain reset, active high
- core_reset_o  out  1  core domain reset, active high
- mb_reset_o  out  1  microblaze reset, active high
- ready_o  out  1  all resets released
- error_o  out  1  retries exhausted
- lock_lost_o  out  1  sticky; lock dropped after release began
- retry_count_o  out  retry_width_p  number of timeouts in the current sequence
- state_o  out  3  current state encoding, for debug

Behaviour:
- All outputs are registered.
- Async reset values:
  - state = PLL_RST; pll_rst_o = 1.
  - io_reset_o = core_reset_o = mb_reset_o = 1.
  - ready_o = error_o = lock_lost_o = 0; retry_count_o = 0.
  - Timer and filter counters = 0; sync flops = 0.
- State encodings: PLL_RST=0, WAIT_LOCK=1, REL_IO=2, REL_CORE=3, RUN=4, FAIL=5.
- PLL_RST:
  - pll_rst_o = 1 and all resets = 1.
  - Timer counts pll_rst_cycles_p cycles, then go to WAIT_LOCK and clear the timer.
  - pll_rst_o is 0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Timer increments every cycle.
  - Filter increments while lock_s = 1 and clears to 0 on any lock_s = 0.
  - Filter reaching lock_filter_p → REL_IO. This takes priority over timeout in the same cycle.
  - Otherwise, timer reaching lock_timeout_p → retry_count increments (saturating).
    - New value == max_retries_p → FAIL.
    - Else → PLL_RST.
- REL_IO:
  - io_reset_o = 0 from the first REL_IO cycle.
  - After io_to_core_delay_p cycles → REL_CORE.
- REL_CORE:
  - core_reset_o = 0 on entry.
  - After core_to_mb_delay_p cycles → RUN.
- RUN: mb_reset_o = 0 and ready_o = 1 on entry; stays in RUN.
- FAIL:
  - error_o = 1, pll_rst_o = 1, all resets = 1.
  - Leaves only on restart_i or async reset.
- Lock loss:
  - Applies in REL_IO, REL_CORE or RUN when lock_s = 0 on any cycle.
  - Next state is PLL_RST; all resets reassert, ready_o = 0, lock_lost_o = 1.
  - retry_count is unchanged.
- restart_i (any state, including FAIL):
  - Next state is PLL_RST; all resets = 1; ready_o = 0.
  - error_o, lock_lost_o and retry_count clear; counters clear.
  - Priority: restart_i > lock loss > timeout / normal progress.
- Latency: pll_locked_i rise to io_reset_o fall is 2 (sync) + lock_filter_p + 1 cycles.
- Reset ordering invariant: a reset is deasserted only if every earlier domain's reset is deasserted. Reassertion of all three happens in the same cycle.
- All counters are sized to their parameter and never wrap. The timer is cleared on every state change.

Test Plan:
- Nominal bring-up (defaults; pll_locked_i rises 100 cycles after reset_n_i release and stays high):
  - pll_rst_o is high for cycles 0–7.
  - io_reset_o falls 67 cycles after the lock rise.
  - core_reset_o falls 32 cycles after io_reset_o.
  - mb_reset_o falls and ready_o rises 32 cycles after core_reset_o.
- Lock glitch during filtering: lock drops for 1 cycle at filter count 40 → filter restarts; release is delayed by 41+ cycles versus nominal; no retry.
- Timeouts to FAIL: pll_locked_i held 0 → retry_count_o steps 1, 2, 3, then FAIL with error_o = 1, pll_rst_o = 1 and retry_count_o = 4.
- Lock loss in RUN: drop lock 1 cycle → 2 sync cycles later all resets = 1, ready_o = 0, lock_lost_o = 1, state_o = 0; a full re-sequence completes after lock returns.
- restart_i while in FAIL and while in REL_CORE → PLL_RST next cycle; error_o, lock_lost_o and retry_count_o are 0.
- Async reset mid-REL_IO (reset_n_i low for half a cycle) → all outputs return to reset values immediately, without waiting for a clock edge.
